// File: rtl/hit_readout_master.sv
// SPI master that reads the 24-bit latched hit pattern from the trigger
// latching register. It publishes the word in parallel with a pair-coverage
// qualifier, then re-arms the register with an active-low clear pulse.
module hit_readout_master #(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned CS_SETUP     = 8,
  parameter int unsigned CS_HOLD      = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned AUTO_TRIGGER = 1
) (
  input  logic        sys_clk_pll,
  input  logic        rst_n,
  input  logic        start,
  input  logic        trigger_in,
  output logic        spi_cs,
  output logic        spi_clk,
  input  logic        spi_miso,
  output logic        latch_clr_n,
  output logic [23:0] data,
  output logic        data_valid,
  output logic        pattern_ok,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SCK_HI, SCK_LO, HOLD, DONE, CLEAR
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] CLR_LAST   = 16'(CLEAR_CYCLES - 1);
  localparam logic        AUTO_EN    = (AUTO_TRIGGER != 0);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [4:0]  bit_cnt, bit_cnt_nx;
  logic [23:0] shreg, shreg_nx;
  logic [7:0]  overrun_nx;
  logic        trig_s1, trig_s2, trig_d, trig_edge;
  logic        miso_s1, miso_s2;
  logic        request;
  logic        pairs_ok;

  // Two-flop synchronizers for trigger and MISO, plus a registered trigger edge
  always_ff @(posedge sys_clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_d    <= 1'b0;
      trig_edge <= 1'b0;
      miso_s1   <= 1'b0;
      miso_s2   <= 1'b0;
    end else begin
      trig_s1   <= trigger_in;
      trig_s2   <= trig_s1;
      trig_d    <= trig_s2;
      trig_edge <= trig_s2 & ~trig_d;
      miso_s1   <= spi_miso;
      miso_s2   <= miso_s1;
    end
  end

  assign request = start | (AUTO_EN & trig_edge);

  // Pattern qualifier: every 2-bit pair of the captured word must be nonzero
  always_comb begin
    pairs_ok = 1'b1;
    for (int unsigned k = 0; k < 12; k++) begin
      if (shreg[2*k +: 2] == 2'b00) pairs_ok = 1'b0;
    end
  end

  // Next-state, timing counter, bit capture and overrun accounting
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 16'd1;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    overrun_nx = overrun_cnt;
    if (request && state != IDLE && overrun_cnt != 8'hFF) begin
      overrun_nx = overrun_cnt + 8'd1;
    end
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (request) begin
          state_nx   = SETUP;
          shreg_nx   = '0;
          bit_cnt_nx = '0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = SCK_HI;
          cnt_nx   = '0;
        end
      end
      SCK_HI: begin
        if (cnt == DIV_LAST) begin
          shreg_nx   = {shreg[22:0], miso_s2};
          bit_cnt_nx = bit_cnt + 5'd1;
          state_nx   = SCK_LO;
          cnt_nx     = '0;
        end
      end
      SCK_LO: begin
        if (cnt == DIV_LAST) begin
          state_nx = (bit_cnt == 5'd24) ? HOLD : SCK_HI;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end
      end
      DONE: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
      CLEAR: begin
        if (cnt == CLR_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sys_clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      overrun_cnt <= overrun_nx;
    end
  end

  // Outputs are registered from the next state so the pins change cleanly
  // on the same edge the FSM enters each state
  always_ff @(posedge sys_clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs      <= 1'b1;
      spi_clk     <= 1'b0;
      latch_clr_n <= 1'b1;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      data        <= '0;
      pattern_ok  <= 1'b0;
    end else begin
      spi_cs      <= !(state_nx == SETUP || state_nx == SCK_HI || state_nx == SCK_LO);
      spi_clk     <= (state_nx == SCK_HI);
      latch_clr_n <= (state_nx != CLEAR);
      busy        <= (state_nx != IDLE);
      data_valid  <= (state_nx == DONE);
      if (state_nx == DONE) begin
        data       <= shreg;
        pattern_ok <= pairs_ok;
      end
    end
  end

endmodule

// File: tb/tb_hit_readout_master.sv
// Bench for hit_readout_master: two instances (defaults with auto-trigger,
// and CLK_DIV=6 without auto-trigger), each driven by a behavioural responder.
module tb_hit_readout_master;

  localparam int S   = 8;
  localparam int H   = 8;
  localparam int CLR = 4;

  logic        clk = 1'b0;
  logic [1:0]  rst_n = '0;
  logic [1:0]  start = '0;
  logic [1:0]  trig  = '0;
  logic [1:0]  cs, sclk, clr_n, dv, pok, busy;
  logic [1:0]  miso = '0;
  logic [23:0] data [2];
  logic [7:0]  ovr  [2];
  logic [23:0] load [2] = '{24'h0, 24'h0};

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hit_readout_master u_dut0 (
    .sys_clk_pll(clk), .rst_n(rst_n[0]), .start(start[0]), .trigger_in(trig[0]),
    .spi_cs(cs[0]), .spi_clk(sclk[0]), .spi_miso(miso[0]), .latch_clr_n(clr_n[0]),
    .data(data[0]), .data_valid(dv[0]), .pattern_ok(pok[0]), .busy(busy[0]),
    .overrun_cnt(ovr[0])
  );

  hit_readout_master #(.CLK_DIV(6), .AUTO_TRIGGER(0)) u_dut1 (
    .sys_clk_pll(clk), .rst_n(rst_n[1]), .start(start[1]), .trigger_in(trig[1]),
    .spi_cs(cs[1]), .spi_clk(sclk[1]), .spi_miso(miso[1]), .latch_clr_n(clr_n[1]),
    .data(data[1]), .data_valid(dv[1]), .pattern_ok(pok[1]), .busy(busy[1]),
    .overrun_cnt(ovr[1])
  );

  function automatic int div(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  // Reference qualifier: count nonzero pairs arithmetically
  function automatic logic model_ok(input logic [23:0] w);
    int nz = 0;
    for (int k = 0; k < 12; k++) begin
      if (((int'(w) >> (2 * k)) % 4) != 0) nz++;
    end
    return (nz == 12);
  endfunction

  // Responder: after seeing each SCLK rise it presents the next bit (MSB
  // first) on MISO three cycles after the rise
  logic [1:0] sclk_q = '0;
  logic [1:0] want = '0;
  logic [1:0] p1 = '0;
  int r_idx [2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sclk_q[i] <= sclk[i];
      if (cs[i]) r_idx[i] <= 0;
      else if (sclk[i] && !sclk_q[i]) begin
        r_idx[i] <= r_idx[i] + 1;
        if (r_idx[i] < 24) want[i] <= load[i][23 - r_idx[i]];
      end
      p1[i]   <= want[i];
      miso[i] <= p1[i];
    end
  end

  // Monitor: pulse widths and edge counts per transaction
  logic [1:0] cs_p = '1;
  logic [1:0] sclk_p = '0;
  logic [1:0] busy_at_clr_rise = '1;
  int cs_run [2] = '{0, 0};
  int last_cs [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int last_rises [2] = '{0, 0};
  int dv_run [2] = '{0, 0};
  int last_dv [2] = '{0, 0};
  int dv_total [2] = '{0, 0};
  int clr_run [2] = '{0, 0};
  int last_clr [2] = '{0, 0};
  int rd_run [2] = '{0, 0};
  int last_rd [2] = '{0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cs_p[i]   <= cs[i];
      sclk_p[i] <= sclk[i];
      if (!cs[i]) cs_run[i] <= cs_run[i] + 1;
      else if (cs_run[i] != 0) begin
        last_cs[i] <= cs_run[i];
        cs_run[i]  <= 0;
      end
      if (!cs[i] && sclk[i] && !sclk_p[i]) rises[i] <= rises[i] + 1;
      else if (cs[i] && rises[i] != 0) begin
        last_rises[i] <= rises[i];
        rises[i]      <= 0;
      end
      if (dv[i]) begin
        dv_run[i] <= dv_run[i] + 1;
        if (dv_run[i] == 0) dv_total[i] <= dv_total[i] + 1;
      end else if (dv_run[i] != 0) begin
        last_dv[i] <= dv_run[i];
        dv_run[i]  <= 0;
      end
      if (!clr_n[i]) clr_run[i] <= clr_run[i] + 1;
      else if (clr_run[i] != 0) begin
        last_clr[i]         <= clr_run[i];
        clr_run[i]          <= 0;
        busy_at_clr_rise[i] <= busy[i];
      end
      if (!cs[i] && cs_p[i]) rd_run[i] <= 1;
      else if (dv[i] && rd_run[i] != 0) begin
        last_rd[i] <= rd_run[i] + 1;
        rd_run[i]  <= 0;
      end else if (rd_run[i] != 0) rd_run[i] <= rd_run[i] + 1;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_dv(input int i, output logic got);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (dv[i]) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int i);
    logic done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy[i]) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("busy_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_read(input int i, input logic [23:0] exp_d, input logic exp_ok,
                             input string nm);
    logic got;
    wait_dv(i, got);
    if (!got) check({nm, "_dv_timeout"}, 0, 1);
    else begin
      check({nm, "_data"}, data[i], exp_d);
      check({nm, "_pattern_ok"}, pok[i], exp_ok);
    end
    wait_idle(i);
    check({nm, "_dv_width"}, last_dv[i], 1);
    check({nm, "_sclk_rises"}, last_rises[i], 24);
    check({nm, "_cs_low"}, last_cs[i], S + 48 * div(i));
    check({nm, "_read_len"}, last_rd[i], S + 48 * div(i) + H + 1);
    check({nm, "_clr_width"}, last_clr[i], CLR);
    check({nm, "_busy_at_clr_rise"}, busy_at_clr_rise[i], 0);
  endtask

  task automatic do_read(input int i, input logic [23:0] w, input logic [23:0] exp_d,
                         input logic exp_ok, input string nm);
    load[i] = w;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    finish_read(i, exp_d, exp_ok, nm);
  endtask

  typedef struct {
    logic [23:0] word;
    logic [23:0] exp_data;
    logic        exp_ok;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int lat;
    int lows;
    int dvt;
    logic [23:0] w;

    // A5C396: pair [13:12] is 00, so it does not qualify
    tbl[0] = '{24'hA5C396, 24'hA5C396, 1'b0};
    tbl[1] = '{24'h00FFFF, 24'h00FFFF, 1'b0};
    tbl[2] = '{24'h555555, 24'h555555, 1'b1};
    tbl[3] = '{24'hAAAAAA, 24'hAAAAAA, 1'b1};
    tbl[4] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1};
    tbl[5] = '{24'h000000, 24'h000000, 1'b0};
    tbl[6] = '{24'h9D7E6B, 24'h9D7E6B, 1'b1};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_cs", cs[i], 1);
      check("rst_sclk", sclk[i], 0);
      check("rst_clr_n", clr_n[i], 1);
      check("rst_data", data[i], 0);
      check("rst_dv", dv[i], 0);
      check("rst_pok", pok[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_ovr", ovr[i], 0);
    end
    rst_n = '1;
    repeat (3) @(negedge clk);

    // Start-to-CS latency is one cycle
    load[0] = 24'hA5C396;
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk);
    #1;
    check("start_latency_cs", cs[0], 0);
    check("start_latency_busy", busy[0], 1);
    @(negedge clk) start[0] = 1'b0;
    finish_read(0, 24'hA5C396, 1'b0, "first");

    for (int v = 0; v < 7; v++) do_read(0, tbl[v].word, tbl[v].exp_data, tbl[v].exp_ok, "table");

    for (int r = 0; r < 16; r++) begin
      w = 24'($urandom);
      do_read(0, w, w, model_ok(w), "random");
    end

    // Start and trigger edge landing in the same IDLE cycle: one request
    load[0] = 24'h5A5A5A;
    @(negedge clk) trig[0] = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    finish_read(0, 24'h5A5A5A, model_ok(24'h5A5A5A), "coincident");
    check("coincident_ovr", ovr[0], 0);
    trig[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Three starts during a read
    load[0] = 24'h13579B;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      repeat (10) @(negedge clk);
    end
    finish_read(0, 24'h13579B, model_ok(24'h13579B), "ovr3");
    check("ovr_three", ovr[0], 3);

    // 300 requests while busy saturate the counter
    load[0] = 24'hC0FFEE;
    @(negedge clk) start[0] = 1'b1;
    repeat (301) @(negedge clk);
    start[0] = 1'b0;
    finish_read(0, 24'hC0FFEE, model_ok(24'hC0FFEE), "ovr_sat");
    check("ovr_saturate", ovr[0], 255);

    // Auto-trigger latency and level-held trigger not restarting
    load[0] = 24'h6B6B6B;
    @(negedge clk) trig[0] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (!cs[0]) begin
        lat = c;
        break;
      end
    end
    check("trigger_latency", lat, 4);
    finish_read(0, 24'h6B6B6B, model_ok(24'h6B6B6B), "trigger");
    lows = 0;
    repeat (50) @(negedge clk) if (!cs[0]) lows++;
    check("trigger_level_no_read", lows, 0);
    trig[0] = 1'b0;

    // Without auto-trigger an edge produces no CS activity
    @(negedge clk) trig[1] = 1'b1;
    lows = 0;
    repeat (50) @(negedge clk) if (!cs[1]) lows++;
    check("no_auto_cs", lows, 0);
    trig[1] = 1'b0;

    // Minimum divider with walking one
    for (int b = 0; b < 24; b++) begin
      w = 24'h000001 << b;
      do_read(1, w, w, model_ok(w), "walk");
    end

    // Reset during bit 12 aborts without publishing
    load[0] = 24'h123456;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    lat = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rises[0] == 12) begin
        lat = 1;
        break;
      end
    end
    check("reach_bit12", lat, 1);
    dvt = dv_total[0];
    rst_n[0] = 1'b0;
    #1;
    check("abort_cs", cs[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_clr_n", clr_n[0], 1);
    check("abort_data", data[0], 0);
    check("abort_busy", busy[0], 0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_no_dv", dv_total[0], dvt);
    do_read(0, 24'h123456, 24'h123456, model_ok(24'h123456), "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
